// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter                                                           |
// | Round-robin arbiter/sequencer for the shared fetch/data memory port with    |
// | fixed-latency reads and registered outputs.                                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [2:0] LAT_M1       = 3'(MEM_LAT - 1);
  localparam bit         SINGLE_CYCLE = (MEM_LAT == 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       last_grant;
  logic       port;
  logic       we_q;
  logic [2:0] cnt;
  logic       grant;
  logic       grant_d;
  logic       capture;
  logic       unused_addr_lsb;

  assign unused_addr_lsb = ^{if_addr[1:0], d_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_d   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant     = 1'b1;
          // On a tie the port that did not win last time goes first.
          grant_d   = (if_req && d_req) ? ~last_grant : d_req;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q || SINGLE_CYCLE) begin
          capture   = ~we_q;
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      port       <= 1'b0;
      we_q       <= 1'b0;
      cnt        <= 3'd0;
      mem_en     <= 1'b0;
      mem_we     <= 4'b0000;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      busy       <= 1'b0;
      if_rdata   <= 32'h0;
      d_rdata    <= 32'h0;
    end else begin
      // Outputs are precomputed from the next state so they line up with it.
      mem_en  <= grant;
      busy    <= (state_nxt != IDLE);
      if_done <= (state_nxt == DONE) && !port;
      d_done  <= (state_nxt == DONE) && port;
      mem_we  <= 4'b0000;

      if (grant) begin
        port       <= grant_d;
        last_grant <= grant_d;
        we_q       <= grant_d & d_we;
        mem_addr   <= grant_d ? {d_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
        if (grant_d && d_we) begin
          mem_we    <= d_be;
          mem_wdata <= d_wdata;
        end
      end

      if (state == ACCESS) begin
        cnt <= LAT_M1;
      end else if (state == WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end

      if (capture) begin
        if (port) begin
          d_rdata <= mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                        |
// | Scoreboard bench: memory model, expected accesses/results queued per port. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic        st;
    logic [31:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  logic        l_d_req = 1'b0;
  logic [31:0] l_d_addr = 32'h0;
  logic [31:0] l_if_rdata;
  logic        l_if_done;
  logic [31:0] l_d_rdata;
  logic        l_d_done;
  logic        l_mem_en;
  logic [3:0]  l_mem_we;
  logic [31:0] l_mem_addr;
  logic [31:0] l_mem_wdata;
  logic [31:0] l_mem_rdata = 32'h0;
  logic        l_busy;

  mem_port_arbiter #(.MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(32'h0), .if_rdata(l_if_rdata), .if_done(l_if_done),
    .d_req(l_d_req), .d_we(1'b0), .d_addr(l_d_addr), .d_wdata(32'h0), .d_be(4'hF),
    .d_rdata(l_d_rdata), .d_done(l_d_done),
    .mem_en(l_mem_en), .mem_we(l_mem_we), .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata),
    .mem_rdata(l_mem_rdata), .busy(l_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] l_q[$];
  acc_t        if_acc_q[$];
  acc_t        d_acc_q[$];
  bit          grant_log[$];
  logic [31:0] exp_d = 32'h0;
  bit          mon_on = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h104) return 32'h00A0_0093;
    return (a ^ 32'h5A5A_A5A5) + 32'h0101_0101;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    logic [31:0] wa = {a[31:2], 2'b00};
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  function automatic void wr_ref(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w = rd_ref(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[{a[31:2], 2'b00}] = w;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  // Memory model: a read issued with mem_en in cycle C is valid only in cycle C+LAT.
  bit          rd_pend = 1'b0;
  int          rd_due = 0;
  logic [31:0] rd_val = 32'h0;
  always @(negedge clk) begin
    if (rst) begin
      rd_pend   = 1'b0;
      mem_rdata = 32'hDEAD_0000;
    end else begin
      if (mem_en) begin
        if (mem_we != 4'b0000) begin
          logic [31:0] w;
          w = rd_mem(mem_addr);
          for (int b = 0; b < 4; b++) if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem[mem_addr] = w;
        end
        rd_pend = 1'b1;
        rd_due  = cyc + LAT;
        rd_val  = rd_mem(mem_addr);
      end
      mem_rdata = (rd_pend && cyc == rd_due) ? rd_val : {16'hDEAD, cyc[15:0]};
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      checks++;
      if ((if_done & d_done) !== 1'b0) begin
        errors++;
        $display("FAIL two_done: if_done=%b d_done=%b, required at most one", if_done, d_done);
      end
      if (mem_en === 1'b1) begin
        acc_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        grant_log.push_back(mem_addr >= 32'h1000);
        if (mem_addr < 32'h1000) begin
          if (if_acc_q.size() > 0) begin e = if_acc_q.pop_front(); have = 1'b1; end
        end else begin
          if (d_acc_q.size() > 0) begin e = d_acc_q.pop_front(); have = 1'b1; end
        end
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL unexpected_access: addr=%h we=%b, required no access", mem_addr, mem_we);
        end else if ({busy, mem_addr, mem_we, (e.st ? mem_wdata : 32'h0)} !==
                     {1'b1, e.addr, e.we, (e.st ? e.wdata : 32'h0)}) begin
          errors++;
          $display("FAIL access: busy=%b addr=%h we=%b wdata=%h, required busy=1 addr=%h we=%b wdata=%h",
                   busy, mem_addr, mem_we, mem_wdata, e.addr, e.we, e.wdata);
        end
      end
      if (if_done === 1'b1) begin
        checks++;
        if (if_q.size() == 0) begin
          errors++;
          $display("FAIL if_done_unexpected: if_rdata=%h, required no done", if_rdata);
        end else begin
          logic [31:0] x;
          x = if_q.pop_front();
          if (if_rdata !== x) begin
            errors++;
            $display("FAIL if_rdata: got %h, required %h", if_rdata, x);
          end
        end
      end
      if (d_done === 1'b1) begin
        checks++;
        if (d_q.size() == 0) begin
          errors++;
          $display("FAIL d_done_unexpected: d_rdata=%h, required no done", d_rdata);
        end else begin
          logic [31:0] x;
          x = d_q.pop_front();
          if (d_rdata !== x) begin
            errors++;
            $display("FAIL d_rdata: got %h, required %h", d_rdata, x);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a, input int exp_lat);
    int k;
    k = 0;
    if_addr = a;
    if_req  = 1'b1;
    if_q.push_back(rd_ref(a));
    if_acc_q.push_back({{a[31:2], 2'b00}, 4'b0000, 1'b0, 32'h0});
    while (k < 50 && if_done !== 1'b1) begin tick(); k++; end
    if (if_done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: addr=%h no if_done after %0d cycles, required done", a, k);
    end else if (exp_lat != 0) begin
      checks++;
      if (k != exp_lat) begin
        errors++;
        $display("FAIL fetch_latency: got %0d cycles, required %0d", k, exp_lat);
      end
    end
    if_req = 1'b0;
  endtask

  task automatic do_d(input logic we, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input int exp_lat);
    int k;
    k = 0;
    d_we = we; d_addr = a; d_be = be; d_wdata = wd; d_req = 1'b1;
    if (we) begin
      wr_ref(a, be, wd);
    end else begin
      exp_d = rd_ref(a);
    end
    d_q.push_back(exp_d);
    d_acc_q.push_back({{a[31:2], 2'b00}, (we ? be : 4'b0000), we, wd});
    while (k < 50 && d_done !== 1'b1) begin tick(); k++; end
    if (d_done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL d_timeout: addr=%h no d_done after %0d cycles, required done", a, k);
    end else if (exp_lat != 0) begin
      checks++;
      if (k != exp_lat) begin
        errors++;
        $display("FAIL d_latency: got %0d cycles, required %0d", k, exp_lat);
      end
    end
    d_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    mon_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({if_done, d_done, mem_en, mem_we, busy, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: busy=%b mem_en=%b addr=%h if_rdata=%h d_rdata=%h, required all 0",
                 busy, mem_en, mem_addr, if_rdata, d_rdata);
      end
    end
  endtask

  task automatic test_round_robin();
    grant_log.delete();
    fork
      begin
        do_fetch(32'h200, 0);
        tick();
        do_fetch(32'h204, 0);
      end
      begin
        do_d(1'b0, 32'h2100, 4'h0, 32'h0, 0);
        tick();
        do_d(1'b1, 32'h2104, 4'hF, 32'h1234_5678, 0);
      end
    join
    checks++;
    if (grant_log.size() != 4) begin
      errors++;
      $display("FAIL rr_count: got %0d grants, required 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_log[i] != bit'(i % 2)) begin
          errors++;
          $display("FAIL rr_order: grant %0d went to port %0d, required %0d", i, grant_log[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_fetch();
    tick();
    do_fetch(32'h104, 2 + LAT);
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_busy_fall: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_store();
    tick();
    do_d(1'b0, 32'h2004, 4'h0, 32'h0, 2 + LAT);
    tick();
    do_d(1'b1, 32'h2003, 4'b1000, 32'hAB00_0000, 2);
    tick();
    do_d(1'b0, 32'h2000, 4'h0, 32'h0, 2 + LAT);
    tick();
    do_d(1'b1, 32'h2000, 4'b0000, 32'hFFFF_FFFF, 2);
    tick();
    do_d(1'b0, 32'h2002, 4'h0, 32'h0, 2 + LAT);
    tick();
    do_fetch(32'h300, 2 + LAT);
  endtask

  task automatic test_rst_mid();
    tick();
    d_we = 1'b0; d_addr = 32'h2200; d_be = 4'h0; d_req = 1'b1;
    d_acc_q.push_back({32'h2200, 4'b0000, 1'b0, 32'h0});
    tick();
    tick();
    rst = 1'b1;
    d_req = 1'b0;
    tick();
    rst = 1'b0;
    exp_d = 32'h0;
    checks++;
    if ({if_done, d_done, mem_en, mem_we, busy, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: busy=%b mem_en=%b d_rdata=%h if_rdata=%h, required all 0",
               busy, mem_en, d_rdata, if_rdata);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({d_done, mem_en, busy} !== 3'b000) begin
        errors++;
        $display("FAIL rst_mid_quiet: d_done=%b mem_en=%b busy=%b, required 0", d_done, mem_en, busy);
      end
    end
  endtask

  task automatic test_lat1();
    logic [31:0] x;
    tick();
    l_d_addr = 32'h0000_0043;
    l_d_req  = 1'b1;
    l_q.push_back(32'h1357_9BDF);
    tick();
    checks++;
    if ({l_mem_en, l_mem_we, l_mem_addr, l_busy} !== {1'b1, 4'b0000, 32'h40, 1'b1}) begin
      errors++;
      $display("FAIL lat1_access: mem_en=%b we=%b addr=%h busy=%b, required 1 0000 00000040 1",
               l_mem_en, l_mem_we, l_mem_addr, l_busy);
    end
    l_mem_rdata = 32'h1357_9BDF;
    tick();
    l_mem_rdata = 32'hDEAD_BEEF;
    x = l_q.pop_front();
    checks++;
    if ({l_d_done, l_d_rdata, l_mem_en} !== {1'b1, x, 1'b0}) begin
      errors++;
      $display("FAIL lat1_done: d_done=%b d_rdata=%h mem_en=%b, required 1 %h 0", l_d_done, l_d_rdata, l_mem_en, x);
    end
    l_d_req = 1'b0;
    tick();
    checks++;
    if ({l_busy, l_d_done, l_mem_en, l_d_rdata} !== {3'b000, x}) begin
      errors++;
      $display("FAIL lat1_after: busy=%b d_done=%b mem_en=%b d_rdata=%h, required 0 0 0 %h",
               l_busy, l_d_done, l_mem_en, l_d_rdata, x);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fetch();
    test_store();
    test_rst_mid();
    test_lat1();
    repeat (3) tick();
    checks++;
    if ((if_q.size() + d_q.size() + if_acc_q.size() + d_acc_q.size()) != 0) begin
      errors++;
      $display("FAIL leftover: if_q=%0d d_q=%0d if_acc=%0d d_acc=%0d, required all 0",
               if_q.size(), d_q.size(), if_acc_q.size(), d_acc_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
